// File: rtl/psum_adder_ctrl.sv
// Sequencer for the psum reduction/binarize pipeline: issues PE vectors with
// incrementing ofmap addresses under downstream credit control, then drains.
module psum_adder_ctrl #(
  parameter int OFMAPS_BRAM_ADDR_WIDTH = 12,
  parameter int CNT_WIDTH              = OFMAPS_BRAM_ADDR_WIDTH + 1,
  parameter int CREDITS                = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [CNT_WIDTH-1:0]              cfg_num_outputs,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                              pe_valid,
  output logic                              pe_ready,
  output logic                              adder_i_valid,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] adder_addr,
  output logic                              adder_layer_finish,
  input  logic                              adder_o_valid,
  input  logic                              adder_o_last,
  input  logic                              cred_ret,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int CRW = $clog2(CREDITS + 1);
  localparam logic [CRW-1:0] CRED_MAX = CRW'(CREDITS);

  typedef enum logic [2:0] {IDLE, RUN, FIN, DRAIN, DONE} state_t;

  state_t                              state, state_nxt;
  logic [CRW-1:0]                      credits;
  logic [CNT_WIDTH-1:0]                issue_cnt;
  logic [CNT_WIDTH-1:0]                res_cnt;
  logic [CNT_WIDTH-1:0]                res_nxt;
  logic [CNT_WIDTH-1:0]                cfg_num;
  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0]   cfg_base;
  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0]   addr_q;
  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0]   addr_issue;
  logic                                start_acc;
  logic                                issue;
  logic                                last_issue;
  logic                                cred_ovf;
  logic                                cnt_mismatch;

  assign start_acc  = start && (state == IDLE);
  assign pe_ready   = (state == RUN) && (credits != '0);
  assign issue      = pe_valid && pe_ready;
  assign last_issue = issue && (issue_cnt == cfg_num - 1'b1);
  assign addr_issue = cfg_base + issue_cnt[OFMAPS_BRAM_ADDR_WIDTH-1:0];

  assign adder_i_valid      = issue;
  assign adder_addr         = issue ? addr_issue : addr_q;
  assign adder_layer_finish = last_issue || (state == FIN);
  assign busy               = (state != IDLE);
  assign done               = (state == DONE);

  // A result arriving in the o_last cycle itself still belongs to this layer.
  assign res_nxt      = res_cnt + CNT_WIDTH'(adder_o_valid);
  assign cnt_mismatch = (state == DRAIN) && adder_o_last && (res_nxt != cfg_num);
  assign cred_ovf     = cred_ret && !issue && (credits == CRED_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_num_outputs == '0) ? FIN : RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      FIN:     state_nxt = DRAIN;
      DRAIN:   if (adder_o_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      credits   <= CRED_MAX;
      issue_cnt <= '0;
      res_cnt   <= '0;
      cfg_num   <= '0;
      cfg_base  <= '0;
      addr_q    <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;

      if (issue && !cred_ret)
        credits <= credits - 1'b1;
      else if (cred_ret && !issue && credits != CRED_MAX)
        credits <= credits + 1'b1;

      if (start_acc) begin
        cfg_num   <= cfg_num_outputs;
        cfg_base  <= cfg_base_addr;
        issue_cnt <= '0;
        res_cnt   <= '0;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + 1'b1;
          addr_q    <= addr_issue;
        end
        if (adder_o_valid && state != IDLE)
          res_cnt <= res_nxt;
      end

      if (start_acc)
        err <= cred_ovf;
      else if (cred_ovf || cnt_mismatch)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_adder_ctrl.sv
// Directed bench for psum_adder_ctrl with a delay-line model of the adder
// (o_valid 10 cycles after i_valid, o_last 11 cycles after layer_finish).
module tb_psum_adder_ctrl;

  localparam int AW = 12;
  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] cfg_num_outputs;
  logic [AW-1:0] cfg_base_addr;
  logic          pe_valid;
  logic          pe_ready;
  logic          adder_i_valid;
  logic [AW-1:0] adder_addr;
  logic          adder_layer_finish;
  logic          adder_o_valid;
  logic          adder_o_last;
  logic          cred_ret;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [9:0]  vpipe;
  logic [10:0] lpipe;
  logic        drop_one;

  always #5 clk = ~clk;

  psum_adder_ctrl #(
    .OFMAPS_BRAM_ADDR_WIDTH(AW),
    .CNT_WIDTH(CW),
    .CREDITS(16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .cfg_num_outputs    (cfg_num_outputs),
    .cfg_base_addr      (cfg_base_addr),
    .pe_valid           (pe_valid),
    .pe_ready           (pe_ready),
    .adder_i_valid      (adder_i_valid),
    .adder_addr         (adder_addr),
    .adder_layer_finish (adder_layer_finish),
    .adder_o_valid      (adder_o_valid),
    .adder_o_last       (adder_o_last),
    .cred_ret           (cred_ret),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  // Adder latency model; drop_one swallows the next issued result.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe <= {vpipe[8:0], adder_i_valid && !drop_one};
      lpipe <= {lpipe[9:0], adder_layer_finish};
      if (adder_i_valid && drop_one) drop_one <= 1'b0;
    end
  end
  assign adder_o_valid = vpipe[9];
  assign adder_o_last  = lpipe[10];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret_credits(input int n);
    for (int k = 0; k < n; k++) begin
      cred_ret = 1'b1;
      tick();
    end
    cred_ret = 1'b0;
  endtask

  // Runs a full layer with pe_valid held high; checks addresses, finish
  // placement, done latency and the final err flag.
  task automatic run_layer(input string tag, input logic [AW-1:0] base, input int num,
                           input logic exp_err);
    int i;
    int n;
    logic [AW-1:0] ea;
    cfg_base_addr   = base;
    cfg_num_outputs = CW'(num);
    pe_valid        = 1'b1;
    start           = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_err_clr"}, err, 0);
    i = 0;
    n = 0;
    if (num == 0) begin
      chk({tag, "_fin_lf"}, adder_layer_finish, 1);
      chk({tag, "_fin_iv"}, adder_i_valid, 0);
      tick();
    end else begin
      while (i < num && n < 200) begin
        if (adder_i_valid) begin
          ea = base + AW'(i);
          chk({tag, "_addr"}, adder_addr, ea);
          chk({tag, "_lf"}, adder_layer_finish, (i == num - 1));
          i++;
        end
        tick();
        n++;
        if (i < num) @(negedge clk);
      end
      chk({tag, "_issues"}, i, num);
    end
    pe_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!done && n < 60) begin
      tick();
      n++;
      @(negedge clk);
    end
    chk({tag, "_done_lat"}, n, 12);
    chk({tag, "_err"}, err, exp_err);
    tick();
    @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic count_issues(input int cycles, output int cnt, output logic [AW-1:0] last);
    cnt  = 0;
    last = '0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (adder_i_valid) begin
        cnt++;
        last = adder_addr;
      end
      tick();
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pe_ready", pe_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", adder_addr, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [AW-1:0] last;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_num_outputs = '0;
    cfg_base_addr = '0;
    pe_valid = 1'b0;
    cred_ret = 1'b0;
    drop_one = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pe_ready", pe_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_addr", adder_addr, 0);
    chk("reset_lf", adder_layer_finish, 0);
    chk("reset_iv", adder_i_valid, 0);
    tick();

    run_layer("t1", 12'h010, 4, 1'b0);
    ret_credits(4);

    // Credit throttle, ignored start, and mid-run reset.
    cfg_base_addr = 12'h100;
    cfg_num_outputs = 13'd40;
    pe_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    count_issues(30, cnt, last);
    chk("t2_issues", cnt, 16);
    chk("t2_last_addr", last, 12'h10F);
    @(negedge clk);
    chk("t2_stalled", pe_ready, 0);
    chk("t2_busy", busy, 1);
    cfg_base_addr = 12'h300;
    cfg_num_outputs = 13'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cred_ret = 1'b1;
    tick();
    cred_ret = 1'b0;
    count_issues(8, cnt, last);
    chk("t2_one_more", cnt, 1);
    chk("t5_start_ignored", last, 12'h110);
    pulse_reset();

    cfg_base_addr = 12'h200;
    cfg_num_outputs = 13'd40;
    start = 1'b1;
    tick();
    start = 1'b0;
    count_issues(30, cnt, last);
    chk("t5_credits_restored", cnt, 16);
    pulse_reset();
    pe_valid = 1'b0;

    cred_ret = 1'b1;
    tick();
    cred_ret = 1'b0;
    @(negedge clk);
    chk("cred_overflow_err", err, 1);
    tick();

    run_layer("t3", 12'h000, 0, 1'b0);
    run_layer("t4", 12'hFFE, 4, 1'b0);
    ret_credits(4);

    drop_one = 1'b1;
    run_layer("t6", 12'h040, 8, 1'b1);
    run_layer("t6b", 12'h000, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
